// File: rtl/boot_copy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | boot_copy_pkg : shared state encoding, ROM size and checksum fold         |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
package boot_copy_pkg;

    localparam int ROM_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Rotate-left-by-one then XOR; word order therefore matters.
    function automatic logic [31:0] cs_fold(input logic [31:0] sum, input logic [31:0] word);
        return {sum[30:0], sum[31]} ^ word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_checksum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | boot_checksum : 32-bit rotl-xor accumulator with clear/enable            |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module boot_checksum
    import boot_copy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] sum_next
);

    logic [31:0] r_sum;

    // With clr and en both low this simply reflects the held sum.
    always_comb begin
        sum_next = r_sum;
        if (clr) begin
            sum_next = '0;
        end else if (en) begin
            sum_next = cs_fold(r_sum, data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else begin
            r_sum <= sum_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_rom_copier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | boot_rom_copier : copies a boot ROM window to RAM and checks its checksum |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module boot_rom_copier
    import boot_copy_pkg::*;
#(
    parameter int          ROM_AW    = 10,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] DEST_BASE = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROM_AW-1:0] src_base,
    input  logic [ROM_AW:0]   word_count,
    input  logic [DATA_W-1:0] expected_sum,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [31:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ROM_AW:0] C_MAX_COUNT = (ROM_AW + 1)'(ROM_WORDS);

    state_t              r_state;
    state_t              w_state_next;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic [31:0]         r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_valid;
    logic [ROM_AW:0]     r_remaining;
    logic [DATA_W-1:0]   r_expected;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [DATA_W-1:0]   r_checksum;

    logic                w_start_acc;
    logic                w_handshake;
    logic [ROM_AW:0]     w_count_clamped;
    logic [DATA_W-1:0]   w_sum_next;

    assign w_start_acc     = (r_state == ST_IDLE) && start;
    assign w_handshake     = (r_state == ST_WRITE) && wr_ready;
    assign w_count_clamped = (word_count > C_MAX_COUNT) ? C_MAX_COUNT : word_count;

    boot_checksum u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_start_acc),
        .en       (r_state == ST_CAPT),
        .data     (rom_rdata),
        .sum_next (w_sum_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (w_count_clamped == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR:  w_state_next = ST_CAPT;
            ST_CAPT:  w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (wr_ready) begin
                    w_state_next = (r_remaining == (ROM_AW + 1)'(1)) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Result registers are cleared on an accepted start so a stale pass never survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr  <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_valid  <= 1'b0;
            r_remaining <= '0;
            r_expected  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                r_rom_addr  <= src_base;
                r_wr_addr   <= DEST_BASE;
                r_remaining <= w_count_clamped;
                r_expected  <= expected_sum;
                r_busy      <= 1'b1;
                r_pass      <= 1'b0;
                r_checksum  <= '0;
            end
            if (r_state == ST_CAPT) begin
                r_wr_data  <= rom_rdata;
                r_wr_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_wr_valid  <= 1'b0;
                r_remaining <= r_remaining - 1'b1;
                r_rom_addr  <= r_rom_addr + 1'b1;
                r_wr_addr   <= r_wr_addr + 32'd4;
            end
            if (r_state == ST_DONE) begin
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_checksum <= w_sum_next;
                r_pass     <= (w_sum_next == r_expected);
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign checksum = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_boot_rom_copier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_boot_rom_copier : directed self-checking bench for boot_rom_copier     |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_boot_rom_copier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  src_base;
    logic [10:0] word_count;
    logic [31:0] expected_sum;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] checksum;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    boot_rom_copier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src_base     (src_base),
        .word_count   (word_count),
        .expected_sum (expected_sum),
        .rom_addr     (rom_addr),
        .rom_rdata    (rom_rdata),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    // ROM model: rom[i] = i, one-cycle synchronous read
    always @(posedge clk) rom_rdata <= {22'd0, rom_addr};

    always @(posedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
    end

    function automatic logic [31:0] rotl1(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

    // Cycle index c counts posedges from the start edge (start edge = 1).
    task automatic run_copy(input logic [9:0] sb, input logic [10:0] wc, input logic [31:0] es,
                            input bit poke, output int done_cyc, output int first_valid,
                            output logic busy_seen);
        wa.delete();
        wd.delete();
        done_cyc    = -1;
        first_valid = 0;
        @(negedge clk);
        src_base = sb; word_count = wc; expected_sum = es; start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        busy_seen = busy;
        for (int c = 1; c <= 4000; c++) begin
            if (wr_valid && first_valid == 0) first_valid = c;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (poke && c == 2) begin
                @(negedge clk);
                start = 1'b1; src_base = 10'd700; word_count = 11'd1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; src_base = '0; word_count = '0;
        expected_sum = '0; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, pass, wr_valid, rom_addr, wr_addr, wr_data, checksum} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b valid=%b ra=%0h wa=%0h wd=%0h cs=%0h want all 0",
                     busy, done, pass, wr_valid, rom_addr, wr_addr, wr_data, checksum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, wr_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got busy/done/valid=%b want 000", {busy, done, wr_valid});
        end
    endtask

    task automatic test_single();
        int dc, fv;
        logic bs;
        run_copy(10'd5, 11'd1, 32'd5, 1'b0, dc, fv, bs);
        total++;
        if (bs !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bs); end
        total++;
        if (fv !== 3) begin bad++; $display("FAIL single_first_valid: got %0d want 3", fv); end
        total++;
        if (dc !== 5) begin bad++; $display("FAIL single_done_cycle: got %0d want 5", dc); end
        total++;
        if (wa.size() !== 1 || wa[0] !== 32'h0001_0000 || wd[0] !== 32'd5) begin
            bad++;
            $display("FAIL single_write: got n=%0d a=%0h d=%0h want n=1 a=10000 d=5",
                     wa.size(), (wa.size() > 0) ? wa[0] : 32'hx, (wd.size() > 0) ? wd[0] : 32'hx);
        end
        total++;
        if (pass !== 1'b1 || checksum !== 32'd5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_result: got pass=%b cs=%0h busy=%b want 1 5 0", pass, checksum, busy);
        end
    endtask

    task automatic test_two();
        int dc, fv;
        logic bs;
        run_copy(10'd1, 11'd2, 32'd0, 1'b0, dc, fv, bs);
        total++;
        if (dc !== 8) begin bad++; $display("FAIL two_done_cycle: got %0d want 8", dc); end
        total++;
        if (wa.size() !== 2 || wa[0] !== 32'h10000 || wd[0] !== 32'd1 ||
            wa[1] !== 32'h10004 || wd[1] !== 32'd2) begin
            bad++;
            $display("FAIL two_writes: got n=%0d want (10000,1)(10004,2)", wa.size());
        end
        total++;
        if (pass !== 1'b1 || checksum !== 32'd0) begin
            bad++;
            $display("FAIL two_result: got pass=%b cs=%0h want 1 0", pass, checksum);
        end
    endtask

    task automatic test_wrap();
        int dc, fv;
        logic bs;
        run_copy(10'd1023, 11'd2, 32'd2046, 1'b0, dc, fv, bs);
        total++;
        if (wd.size() !== 2 || wd[0] !== 32'd1023 || wd[1] !== 32'd0 || wa[1] !== 32'h10004) begin
            bad++;
            $display("FAIL wrap_writes: got n=%0d want data 3ff then 0", wd.size());
        end
        total++;
        if (rom_addr !== 10'd1) begin bad++; $display("FAIL wrap_rom_addr: got %0d want 1", rom_addr); end
        total++;
        if (pass !== 1'b1 || checksum !== 32'd2046) begin
            bad++;
            $display("FAIL wrap_result: got pass=%b cs=%0h want 1 7fe", pass, checksum);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0, d0;
        logic        stable;
        int          dc;
        wa.delete();
        wd.delete();
        @(negedge clk);
        wr_ready = 1'b0;
        src_base = 10'd1; word_count = 11'd2; expected_sum = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !wr_valid; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (wr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", wr_valid); end
        a0 = wr_addr;
        d0 = wr_data;
        stable = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            if (wr_valid !== 1'b1 || wr_addr !== a0 || wr_data !== d0) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1 || a0 !== 32'h10000 || d0 !== 32'd1) begin
            bad++;
            $display("FAIL stall_hold: got stable=%b a=%0h d=%0h want 1 10000 1", stable, a0, d0);
        end
        total++;
        if (wa.size() !== 0) begin bad++; $display("FAIL stall_no_write: got %0d want 0", wa.size()); end
        @(negedge clk);
        wr_ready = 1'b1;
        dc = -1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done) begin dc = c; break; end
        end
        total++;
        if (dc < 0 || wa.size() !== 2 || wd[0] !== 32'd1 || wd[1] !== 32'd2) begin
            bad++;
            $display("FAIL stall_finish: got done_at=%0d n=%0d want done and 2 writes", dc, wa.size());
        end
        total++;
        if (pass !== 1'b1 || checksum !== 32'd0) begin
            bad++;
            $display("FAIL stall_result: got pass=%b cs=%0h want 1 0", pass, checksum);
        end
    endtask

    task automatic test_zero();
        int dc, fv;
        logic bs;
        run_copy(10'd9, 11'd0, 32'd0, 1'b0, dc, fv, bs);
        total++;
        if (dc !== 2 || fv !== 0 || wa.size() !== 0) begin
            bad++;
            $display("FAIL zero_timing: got done=%0d valid_at=%0d n=%0d want 2 0 0", dc, fv, wa.size());
        end
        total++;
        if (pass !== 1'b1 || checksum !== 32'd0) begin
            bad++;
            $display("FAIL zero_pass: got pass=%b cs=%0h want 1 0", pass, checksum);
        end
        run_copy(10'd9, 11'd0, 32'd1, 1'b0, dc, fv, bs);
        total++;
        if (pass !== 1'b0 || dc !== 2) begin
            bad++;
            $display("FAIL zero_fail: got pass=%b done=%0d want 0 2", pass, dc);
        end
    endtask

    task automatic test_clamp();
        int          dc, fv;
        logic        bs;
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 1024; i++) s = rotl1(s) ^ 32'(i);
        run_copy(10'd0, 11'h7FF, s, 1'b0, dc, fv, bs);
        total++;
        if (dc !== 3074 || wa.size() !== 1024) begin
            bad++;
            $display("FAIL clamp_count: got done=%0d n=%0d want 3074 1024", dc, wa.size());
        end
        total++;
        if (wa.size() == 1024 && (wa[1023] !== 32'h10FFC || wd[1023] !== 32'd1023)) begin
            bad++;
            $display("FAIL clamp_last: got a=%0h d=%0h want 10ffc 3ff", wa[1023], wd[1023]);
        end
        total++;
        if (pass !== 1'b1 || checksum !== s) begin
            bad++;
            $display("FAIL clamp_result: got pass=%b cs=%0h want 1 %0h", pass, checksum, s);
        end
    endtask

    task automatic test_reset_abort();
        int dc, fv;
        logic bs;
        @(negedge clk);
        src_base = 10'd10; word_count = 11'd4; expected_sum = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !wr_valid; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, pass, wr_valid, rom_addr, wr_addr, wr_data, checksum} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b valid=%b ra=%0h wa=%0h wd=%0h want all 0",
                     busy, wr_valid, rom_addr, wr_addr, wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_copy(10'd20, 11'd3, 32'd108, 1'b1, dc, fv, bs);
        total++;
        if (dc !== 11 || wd.size() !== 3 || wd[0] !== 32'd20 || wd[1] !== 32'd21 || wd[2] !== 32'd22) begin
            bad++;
            $display("FAIL abort_recopy: got done=%0d n=%0d want 11 3 (20,21,22)", dc, wd.size());
        end
        total++;
        if (pass !== 1'b1 || checksum !== 32'd108) begin
            bad++;
            $display("FAIL abort_result: got pass=%b cs=%0h want 1 6c", pass, checksum);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_wrap();
        test_stall();
        test_zero();
        test_clamp();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
